state_dump_unit: RTL
====================

Name: state_dump_unit

Overview:
- Synthesizable snapshot streamer for the single-cycle CPU.
- On a trigger it freezes the CPU and walks PC, data memory and register file through asynchronous read ports.
- It emits each word as a tagged valid/ready stream toward a debug sink (UART/trace FIFO).
- Parametrised in data width, memory depth and register count; adds backpressure, overrun detection and back-to-back frames.

Parameters:
- DATA_W, 32, width of PC, memory words and registers.
- MEM_WORDS, 32, number of data-memory words dumped (indices 0..MEM_WORDS-1); ≥1.
- REG_COUNT, 32, number of registers dumped (indices 0..REG_COUNT-1); ≥1.
- IDX_W, $clog2(max(MEM_WORDS,REG_COUNT)), width of index ports (derived, not overridden).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-low reset.
- trig_i  in  1  snapshot request, sampled each cycle.
- pc_i  in  DATA_W  current PC.
- mem_rd_idx_o  out  IDX_W  data-memory read index.
- mem_rd_data_i  in  DATA_W  combinational read data for mem_rd_idx_o.
- reg_rd_idx_o  out  IDX_W  register-file read index.
- reg_rd_data_i  in  DATA_W  combinational read data for reg_rd_idx_o.
- freeze_o  out  1  CPU stall request; high whenever a frame is in progress.
- dump_valid_o  out  1  stream word valid.
- dump_ready_i  in  1  sink ready.
- dump_data_o  out  DATA_W  stream word.
- dump_tag_o  out  2  0=PC, 1=MEM, 2=REG, 3=CSUM.
- dump_idx_o  out  IDX_W  word index within its tag; 0 for PC/CSUM.
- dump_last_o  out  1  final word of frame.
- overrun_o  out  1  sticky: a trigger arrived while busy.

Behaviour:
- Reset (rst_i=0 at posedge): state IDLE, all outputs 0, counters 0, captured PC 0, overrun_o cleared. Applies mid-frame; the partial frame is dropped with no last word emitted.
- FSM states:
  - IDLE: trig_i=1 captures pc_i and moves to S_PC next cycle. Latency from trigger to first valid is 1 cycle.
  - S_PC: valid=1, tag=0, data=captured PC. On handshake, go to S_MEM with count=0.
  - S_MEM: valid=1, tag=1, mem_rd_idx_o=dump_idx_o=count, data=mem_rd_data_i passthrough. Handshake increments count. Handshake at MEM_WORDS-1 goes to S_REG with count=0.
  - S_REG: same scheme with the register port. Handshake at REG_COUNT-1 ends the frame.
- Handshake means valid & ready in the same cycle. While valid & !ready, tag, idx, data and last hold stable; data stability is guaranteed by freeze_o.
- freeze_o = (state != IDLE); it deasserts the cycle after the final handshake.
- dump_last_o is high only on the final word: the last REG word, or the CSUM word when the optional feature is enabled.
- Frame length is 1+MEM_WORDS+REG_COUNT words (+1 with checksum). Minimum duration equals the frame length in cycles with ready held high.
- Back-to-back frames: trig_i high in the final-handshake cycle is accepted. It captures pc_i and goes directly to S_PC with no idle cycle, and does not set overrun.
- Overrun: trig_i high in any other busy cycle is ignored and sets overrun_o, which stays set until reset.
- Index outputs are 0 in states where their port is unused.

Optional Feature:
- Macro: STATE_DUMP_CSUM_EN.
- Defined: a state S_CSUM follows S_REG. It emits tag=3, idx=0, data = XOR of every word handshaken in the frame, with last=1. The accumulator is cleared on frame start and on reset.
- Undefined: no S_CSUM state and no accumulator logic; tag 3 never appears; last is on the final REG word.

Decomposition:
- Shared package dump_pkg: tag constants (TAG_PC, TAG_MEM, TAG_REG, TAG_CSUM), state enum encoding, and a max() helper function for IDX_W.
- One natural sub-module: dump_csum_acc, an XOR accumulator with clear and enable inputs, instantiated only under STATE_DUMP_CSUM_EN.

Test Plan:
- MEM_WORDS=4, REG_COUNT=4, ready=1, pc_i=0x40, mem[k]=k+10, reg[k]=k+100; pulse trig -> 9 words 0x40,10,11,12,13,100..103 with tags 0,1×4,2×4; last only on 103; freeze high exactly 9 cycles.
- Same setup, ready toggled 1-0-0-1 pattern -> identical word sequence; outputs stable across every stalled cycle; freeze spans the full stall.
- trig pulsed again at the 3rd word -> overrun_o=1 and stays 1; frame unaffected; no second frame.
- trig held high through the final handshake -> second frame starts next cycle with freeze continuously high, overrun_o=0.
- rst_i=0 for one cycle at the 5th word -> next cycle valid=0, freeze=0, overrun=0; a new trigger yields a complete fresh frame.
- With STATE_DUMP_CSUM_EN, first scenario data -> 10th word tag=3, data=0x40^10^11^12^13^100^101^102^103, last=1 only there.

Source files
------------

// File: rtl/dump_pkg.sv
// Shared definitions for the state dump streamer.
//   - stream tag encodings (TAG_PC, TAG_MEM, TAG_REG, TAG_CSUM)
//   - FSM state encoding
//   - max() helper used to size the index ports
package dump_pkg;

   localparam logic [1:0] TAG_PC   = 2'd0;
   localparam logic [1:0] TAG_MEM  = 2'd1;
   localparam logic [1:0] TAG_REG  = 2'd2;
   localparam logic [1:0] TAG_CSUM = 2'd3;

   typedef enum logic [2:0] {
      StIdle,
      StPc,
      StMem,
      StReg,
      StCsum
   } dump_state_e;

   function automatic int unsigned max(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/dump_csum_acc.sv
// XOR accumulator for the optional frame checksum.
// Ports:
//   clk_i   clock, rising edge
//   rst_i   synchronous active-low reset
//   clr_i   clear accumulator (has priority over en_i)
//   en_i    fold data_i into the accumulator
//   data_i  word to fold in
//   acc_o   current accumulated XOR
module dump_csum_acc #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clr_i,
   input  logic              en_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] acc_o
);

   logic [DATA_W-1:0] acc_q, acc_d;

   always_comb begin
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (en_i) begin
         acc_d = acc_q ^ data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/state_dump_unit.sv
// Snapshot streamer for the single-cycle CPU. On a trigger it freezes the CPU and streams
// the captured PC, then data memory words 0..MEM_WORDS-1, then registers 0..REG_COUNT-1 as
// tagged words over a valid/ready interface.
// Optional macro STATE_DUMP_CSUM_EN appends an XOR checksum word (tag 3) to each frame.
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-low reset
//   trig_i         snapshot request
//   pc_i           current PC
//   mem_rd_idx_o   data-memory read index (0 when unused)
//   mem_rd_data_i  combinational data-memory read data
//   reg_rd_idx_o   register-file read index (0 when unused)
//   reg_rd_data_i  combinational register read data
//   freeze_o       CPU stall request, high while a frame is in progress
//   dump_valid_o   stream word valid
//   dump_ready_i   sink ready
//   dump_data_o    stream word
//   dump_tag_o     0=PC 1=MEM 2=REG 3=CSUM
//   dump_idx_o     index within the tag (0 for PC/CSUM)
//   dump_last_o    final word of frame
//   overrun_o      sticky: trigger seen while busy
module state_dump_unit
   import dump_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MEM_WORDS = 32,
   parameter int unsigned REG_COUNT = 32,
   parameter int unsigned IDX_W     = (dump_pkg::max(MEM_WORDS, REG_COUNT) > 1) ?
                                      $clog2(dump_pkg::max(MEM_WORDS, REG_COUNT)) : 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              trig_i,
   input  logic [DATA_W-1:0] pc_i,
   output logic [IDX_W-1:0]  mem_rd_idx_o,
   input  logic [DATA_W-1:0] mem_rd_data_i,
   output logic [IDX_W-1:0]  reg_rd_idx_o,
   input  logic [DATA_W-1:0] reg_rd_data_i,
   output logic              freeze_o,
   output logic              dump_valid_o,
   input  logic              dump_ready_i,
   output logic [DATA_W-1:0] dump_data_o,
   output logic [1:0]        dump_tag_o,
   output logic [IDX_W-1:0]  dump_idx_o,
   output logic              dump_last_o,
   output logic              overrun_o
);

   localparam logic [IDX_W-1:0] MemLast = IDX_W'(MEM_WORDS - 1);
   localparam logic [IDX_W-1:0] RegLast = IDX_W'(REG_COUNT - 1);

   dump_state_e       state_q, state_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] pc_q, pc_d;
   logic              overrun_q, overrun_d;

   logic busy;
   logic hs;
   logic last_word;
   logic final_hs;
   logic start;

   assign busy = (state_q != StIdle);
   // valid is exactly busy, so a handshake is busy & ready
   assign hs   = busy & dump_ready_i;

`ifdef STATE_DUMP_CSUM_EN
   logic [DATA_W-1:0] csum;

   assign last_word = (state_q == StCsum);

   dump_csum_acc #(
      .DATA_W(DATA_W)
   ) u_csum_acc (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (start),
      .en_i  (hs & (state_q != StCsum)),
      .data_i(dump_data_o),
      .acc_o (csum)
   );
`else
   assign last_word = (state_q == StReg) && (cnt_q == RegLast);
`endif

   assign final_hs = hs & last_word;
   // A new frame starts from idle, or back-to-back on the final handshake
   assign start    = trig_i & (~busy | final_hs);

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         pc_q      <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pc_q      <= pc_d;
         overrun_q <= overrun_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pc_d      = start ? pc_i : pc_q;
      overrun_d = overrun_q | (trig_i & busy & ~final_hs);
      unique case (state_q)
         StIdle: begin
            if (trig_i) state_d = StPc;
         end
         StPc: begin
            if (hs) begin
               state_d = StMem;
               cnt_d   = '0;
            end
         end
         StMem: begin
            if (hs) begin
               if (cnt_q == MemLast) begin
                  state_d = StReg;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + IDX_W'(1);
               end
            end
         end
         StReg: begin
            if (hs) begin
               if (cnt_q == RegLast) begin
                  cnt_d = '0;
`ifdef STATE_DUMP_CSUM_EN
                  state_d = StCsum;
`else
                  state_d = trig_i ? StPc : StIdle;
`endif
               end else begin
                  cnt_d = cnt_q + IDX_W'(1);
               end
            end
         end
`ifdef STATE_DUMP_CSUM_EN
         StCsum: begin
            if (hs) state_d = trig_i ? StPc : StIdle;
         end
`endif
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      freeze_o     = busy;
      dump_valid_o = busy;
      dump_last_o  = last_word;
      dump_tag_o   = TAG_PC;
      dump_idx_o   = '0;
      dump_data_o  = '0;
      mem_rd_idx_o = '0;
      reg_rd_idx_o = '0;
      case (state_q)
         StPc: begin
            dump_data_o = pc_q;
         end
         StMem: begin
            dump_tag_o   = TAG_MEM;
            dump_idx_o   = cnt_q;
            mem_rd_idx_o = cnt_q;
            dump_data_o  = mem_rd_data_i;
         end
         StReg: begin
            dump_tag_o   = TAG_REG;
            dump_idx_o   = cnt_q;
            reg_rd_idx_o = cnt_q;
            dump_data_o  = reg_rd_data_i;
         end
`ifdef STATE_DUMP_CSUM_EN
         StCsum: begin
            dump_tag_o  = TAG_CSUM;
            dump_data_o = csum;
         end
`endif
         default: ;
      endcase
   end

   assign overrun_o = overrun_q;

endmodule
